alu_exec: RTL and testbench

Execute stage between the register file's read ports and its write port. It takes both source operands plus a destination address, computes the result, and returns it as a one-cycle register write strobe. Most ops complete in one cycle. The optional multiply is a W-cycle shift-add with a busy stall toward issue logic. Result is W bits; Carry and Zero flags are registered for branch logic.

---
 rtl/alu_exec.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute stage between register-file read ports and write port, one-cycle write strobe.
// Define ALU_MUL_EN to build op 7 as a W-cycle shift-add multiply; otherwise op 7 is a NOP.
module alu_exec #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [3:0]   Op,
    input  logic [D-1:0] Dest_address,
    input  logic [W-1:0] Operand_0,
    input  logic [W-1:0] Operand_1,
    output logic         Busy,
    output logic         Done,
    output logic         Reg_write_en,
    output logic [D-1:0] Reg_write_address,
    output logic [W-1:0] Reg_write_data,
    output logic         Carry_flag,
    output logic         Zero_flag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd2;
`ifdef ALU_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam int unsigned CW     = (W > 1) ? $clog2(W) : 1;
`endif

    logic [1:0]   state_q;
    logic         done_q;
    logic         we_q;
    logic [D-1:0] waddr_q;
    logic [W-1:0] wdata_q;
    logic         carry_q;
    logic         zero_q;

    logic         accept;
    logic         op_nop;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [W:0]   shl_w;
    logic [W:0]   shr_w;
    logic [2:0]   shamt;

`ifdef ALU_MUL_EN
    logic          busy_q;
    logic          op_mul;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [D-1:0]  mdest_q;
    logic [W:0]    step_sum;
    logic [W-1:0]  hi_n;
    logic [W-1:0]  lo_n;

    // Right-shifting accumulator: lo holds the unconsumed multiplier bits, then the low product.
    assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign hi_n     = step_sum[W:1];
    assign lo_n     = {step_sum[0], lo_q[W-1:1]};

    assign Busy   = busy_q;
    assign accept = Start && !busy_q;
`else
    assign Busy   = 1'b0;
    assign accept = Start;
`endif

    assign shamt = Operand_1[2:0];
    assign add_w = {1'b0, Operand_0} + {1'b0, Operand_1};
    assign sub_w = {1'b0, Operand_0} - {1'b0, Operand_1};
    // Spare bit on the far side of each shift catches the last bit shifted out.
    assign shl_w = {1'b0, Operand_0} << shamt;
    assign shr_w = {Operand_0, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        op_nop  = 1'b0;
`ifdef ALU_MUL_EN
        op_mul  = 1'b0;
`endif
        case (Op)
            4'd0: begin
                alu_res = add_w[W-1:0];
                alu_c   = add_w[W];
            end
            4'd1: begin
                alu_res = sub_w[W-1:0];
                alu_c   = sub_w[W];
            end
            4'd2: alu_res = Operand_0 & Operand_1;
            4'd3: alu_res = Operand_0 | Operand_1;
            4'd4: alu_res = Operand_0 ^ Operand_1;
            4'd5: begin
                alu_res = shl_w[W-1:0];
                alu_c   = shl_w[W];
            end
            4'd6: begin
                alu_res = shr_w[W:1];
                alu_c   = shr_w[0];
            end
`ifdef ALU_MUL_EN
            4'd7: op_mul = 1'b1;
`endif
            4'd8: alu_res = Operand_1;
            default: op_nop = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mdest_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= ST_WB;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        we_q    <= 1'b1;
                        waddr_q <= mdest_q;
                        wdata_q <= lo_n;
                        carry_q <= |hi_n;
                        zero_q  <= (lo_n == '0);
                    end
                end
`endif
                // IDLE and WB share the accept path so WB can issue back-to-back.
                default: begin
                    state_q <= ST_IDLE;
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (op_mul) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(W - 1);
                            mcand_q <= Operand_0;
                            hi_q    <= '0;
                            lo_q    <= Operand_1;
                            mdest_q <= Dest_address;
                        end else
`endif
                        begin
                            state_q <= ST_WB;
                            done_q  <= 1'b1;
                            if (!op_nop) begin
                                we_q    <= 1'b1;
                                waddr_q <= Dest_address;
                                wdata_q <= alu_res;
                                carry_q <= alu_c;
                                zero_q  <= (alu_res == '0);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign Done              = done_q;
    assign Reg_write_en      = we_q;
    assign Reg_write_address = waddr_q;
    assign Reg_write_data    = wdata_q;
    assign Carry_flag        = carry_q;
    assign Zero_flag         = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against an arithmetic reference model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_exec;

    localparam int unsigned W    = 8;
    localparam int unsigned D    = 3;
    localparam int          MASK = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         Reset_n = 1'b1;
    logic         Start = 1'b0;
    logic [3:0]   Op = '0;
    logic [D-1:0] Dest_address = '0;
    logic [W-1:0] Operand_0 = '0;
    logic [W-1:0] Operand_1 = '0;
    logic         Busy;
    logic         Done;
    logic         Reg_write_en;
    logic [D-1:0] Reg_write_address;
    logic [W-1:0] Reg_write_data;
    logic         Carry_flag;
    logic         Zero_flag;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_c    = 0;
    int exp_z    = 0;

    alu_exec #(.W(W), .D(D)) dut (
        .CLK               (CLK),
        .Reset_n           (Reset_n),
        .Start             (Start),
        .Op                (Op),
        .Dest_address      (Dest_address),
        .Operand_0         (Operand_0),
        .Operand_1         (Operand_1),
        .Busy              (Busy),
        .Done              (Done),
        .Reg_write_en      (Reg_write_en),
        .Reg_write_address (Reg_write_address),
        .Reg_write_data    (Reg_write_data),
        .Carry_flag        (Carry_flag),
        .Zero_flag         (Zero_flag)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Result, carry, NOP-ness and stall length straight from the op table.
    task automatic ref_model(input int op, input int a, input int b,
                             output int res, output int c, output bit nop, output int lat);
        int s;
        int t;
        res = 0; c = 0; nop = 1'b0; lat = 0;
        s = b & 7;
        case (op)
            0: begin t = a + b; res = t & MASK; c = (t > MASK) ? 1 : 0; end
            1: begin res = (a - b) & MASK; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a << s) & MASK; c = (s != 0) ? ((a >> (W - s)) & 1) : 0; end
            6: begin res = a >> s; c = (s != 0) ? ((a >> (s - 1)) & 1) : 0; end
`ifdef ALU_MUL_EN
            7: begin t = a * b; res = t & MASK; c = ((t >> W) != 0) ? 1 : 0; lat = W; end
`endif
            8: res = b;
            default: nop = 1'b1;
        endcase
    endtask

    // Issue at a negedge, scribble inputs while stalled, check at the write-back negedge.
    task automatic do_op(input string tag, input int op, input int a, input int b, input int dest);
        int res, c, lat, nb;
        bit nop;
        ref_model(op, a, b, res, c, nop, lat);
        Start = 1'b1;
        Op = op[3:0];
        Operand_0 = a[W-1:0];
        Operand_1 = b[W-1:0];
        Dest_address = dest[D-1:0];
        @(negedge CLK);
        nb = 0;
        while (Busy === 1'b1 && nb < 4 * W) begin
            nb++;
            Op = 4'($urandom);
            Operand_0 = W'($urandom);
            Operand_1 = W'($urandom);
            Dest_address = D'($urandom);
            @(negedge CLK);
        end
        Start = 1'b0;
        check_eq({tag, " busy cycles"}, nb, lat);
        check_eq({tag, " done"}, Done, 1);
        check_eq({tag, " write_en"}, Reg_write_en, {31'd0, !nop});
        if (!nop) begin
            exp_c = c;
            exp_z = (res == 0) ? 1 : 0;
            check_eq({tag, " addr"}, Reg_write_address, dest);
            check_eq({tag, " data"}, Reg_write_data, res);
        end
        check_eq({tag, " carry"}, Carry_flag, exp_c);
        check_eq({tag, " zero"}, Zero_flag, exp_z);
    endtask

    initial begin
        int t_sub, nb, saw, gap;
        #1 Reset_n = 1'b0;
        #2;
        check_eq("rst busy", Busy, 0);
        check_eq("rst done", Done, 0);
        check_eq("rst write_en", Reg_write_en, 0);
        check_eq("rst addr", Reg_write_address, 0);
        check_eq("rst data", Reg_write_data, 0);
        check_eq("rst carry", Carry_flag, 0);
        check_eq("rst zero", Zero_flag, 0);
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);

        do_op("add", 0, 200, 100, 3);
        @(negedge CLK);
        check_eq("idle done", Done, 0);

        do_op("sub", 1, 5, 7, 2);
        t_sub = cyc;
        do_op("shl", 5, 'h81, 1, 4);
        check_eq("b2b spacing", cyc - t_sub, 1);

        do_op("add zero", 0, 0, 0, 1);
        do_op("nop12", 12, 9, 9, 7);
        do_op("op7", 7, 3, 5, 6);

`ifdef ALU_MUL_EN
        do_op("mul 13x11", 7, 13, 11, 2);
        do_op("mul 20x20", 7, 20, 20, 3);

        // ADD held during the stall is accepted only in the multiply's write-back cycle.
        Start = 1'b1; Op = 4'd7; Operand_0 = 8'd13; Operand_1 = 8'd11; Dest_address = 3'd6;
        @(negedge CLK);
        Op = 4'd0; Operand_0 = 8'd50; Operand_1 = 8'd60; Dest_address = 3'd5;
        nb = 0;
        while (Busy === 1'b1 && nb < 4 * W) begin
            nb++;
            @(negedge CLK);
        end
        check_eq("held busy cycles", nb, W);
        check_eq("held mul data", Reg_write_data, 143);
        check_eq("held mul addr", Reg_write_address, 6);
        @(negedge CLK);
        Start = 1'b0;
        check_eq("held add done", Done, 1);
        check_eq("held add write_en", Reg_write_en, 1);
        check_eq("held add addr", Reg_write_address, 5);
        check_eq("held add data", Reg_write_data, 110);
        check_eq("held add busy", Busy, 0);
        exp_c = 0; exp_z = 0;

        Start = 1'b1; Op = 4'd7; Operand_0 = 8'd9; Operand_1 = 8'd9; Dest_address = 3'd1;
        repeat (4) @(negedge CLK);
        check_eq("mid-mul busy", Busy, 1);
`else
        Start = 1'b1; Op = 4'd0; Operand_0 = 8'd9; Operand_1 = 8'd9; Dest_address = 3'd1;
        @(negedge CLK);
`endif
        Start = 1'b0;
        Reset_n = 1'b0;
        #1;
        check_eq("abort busy", Busy, 0);
        check_eq("abort done", Done, 0);
        check_eq("abort write_en", Reg_write_en, 0);
        check_eq("abort addr", Reg_write_address, 0);
        check_eq("abort data", Reg_write_data, 0);
        check_eq("abort carry", Carry_flag, 0);
        check_eq("abort zero", Zero_flag, 0);
        exp_c = 0; exp_z = 0;
        @(negedge CLK);
        Reset_n = 1'b1;
        saw = 0;
        repeat (2 * W) begin
            @(negedge CLK);
            if (Reg_write_en !== 1'b0 || Done !== 1'b0) saw = 1;
        end
        check_eq("no write after abort", saw, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                gap = $urandom_range(1, 3);
                repeat (gap) @(negedge CLK);
            end
            do_op("rand", $urandom_range(0, 11), $urandom_range(0, MASK),
                  $urandom_range(0, MASK), $urandom_range(0, (1 << D) - 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
